// File: rtl/regfile_scan_pkg.sv
// Shared scan FSM encoding and default geometry for the scan-capable register file.
package regfile_scan_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_DEPTH    = 32;
  localparam int DEF_RD_PORTS = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/regfile_scan_ctrl.sv
// Scan dump sequencer: walks indices 0..DEPTH-1 under a valid/ready handshake and
// tells the storage side when and which entry to snapshot.
module regfile_scan_ctrl
  import regfile_scan_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scan_start,
  input  logic              scan_ready,
  output logic              scan_busy,
  output logic              scan_valid,
  output logic              scan_done,
  output logic [ADDR_W-1:0] scan_idx,
  output logic              load_en,
  output logic [ADDR_W-1:0] load_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

  scan_state_e       state_r;
  scan_state_e       state_next_s;
  logic [ADDR_W-1:0] idx_r;
  logic [ADDR_W-1:0] idx_next_s;
  logic              busy_r;
  logic              valid_r;
  logic              done_r;

  // Next state, next index and entry-load request
  always_comb begin
    state_next_s = state_r;
    idx_next_s   = idx_r;
    load_en      = 1'b0;
    load_idx     = idx_r;
    case (state_r)
      ST_IDLE: begin
        if (scan_start) begin
          state_next_s = ST_SCAN;
          idx_next_s   = '0;
          load_en      = 1'b1;
          load_idx     = '0;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // scan_valid is always high here, so ready alone completes a handshake
        if (scan_ready) begin
          if (idx_r == LAST_IDX) begin
            state_next_s = ST_DONE;
            idx_next_s   = '0;
          end else begin
            idx_next_s = idx_r + ONE_IDX;
            load_en    = 1'b1;
            load_idx   = idx_r + ONE_IDX;
          end
        end else begin
          state_next_s = ST_SCAN;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
        idx_next_s   = '0;
      end
    endcase
  end

  // State, index and registered status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      idx_r   <= idx_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      valid_r <= (state_next_s == ST_SCAN);
      done_r  <= (state_next_s == ST_DONE);
    end
  end

  assign scan_busy  = busy_r;
  assign scan_valid = valid_r;
  assign scan_done  = done_r;
  assign scan_idx   = idx_r;

endmodule

// File: rtl/regfile_scan.sv
// Register file with r0 hardwired to zero, RD_PORTS combinational read ports and a
// handshaked full-dump scan port. Define REGFILE_BYPASS_EN for write-to-read forwarding.
module regfile_scan
  import regfile_scan_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int RD_PORTS = DEF_RD_PORTS,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [RD_PORTS*ADDR_W-1:0] raddr,
  output logic [RD_PORTS*DATA_W-1:0] rdata,
  input  logic                       scan_start,
  output logic                       scan_busy,
  output logic                       scan_valid,
  input  logic                       scan_ready,
  output logic [ADDR_W-1:0]          scan_idx,
  output logic [DATA_W-1:0]          scan_data,
  output logic                       scan_done
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] scan_data_r;
  logic              wr_en_s;
  logic              load_en_s;
  logic [ADDR_W-1:0] load_idx_s;

  assign wr_en_s = we && (waddr != '0);

  // Storage array; r0 is never written so it stays at its reset value of zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read muxes, one slice of rdata per port
  always_comb begin
    rdata = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (raddr[p*ADDR_W +: ADDR_W] == '0) begin
        rdata[p*DATA_W +: DATA_W] = '0;
`ifdef REGFILE_BYPASS_EN
      end else if (wr_en_s && (waddr == raddr[p*ADDR_W +: ADDR_W])) begin
        rdata[p*DATA_W +: DATA_W] = wdata;
`endif
      end else begin
        rdata[p*DATA_W +: DATA_W] = mem_r[raddr[p*ADDR_W +: ADDR_W]];
      end
    end
  end

  regfile_scan_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk        (clk),
    .reset      (reset),
    .scan_start (scan_start),
    .scan_ready (scan_ready),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_done  (scan_done),
    .scan_idx   (scan_idx),
    .load_en    (load_en_s),
    .load_idx   (load_idx_s)
  );

  // Per-entry snapshot, write-first so a same-edge write to the new index is captured
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_data_r <= '0;
    end else if (load_en_s) begin
      if (wr_en_s && (waddr == load_idx_s)) begin
        scan_data_r <= wdata;
      end else begin
        scan_data_r <= mem_r[load_idx_s];
      end
    end
  end

  assign scan_data = scan_data_r;

endmodule

// File: tb/tb_regfile_scan.sv
// Self-checking bench for regfile_scan: table-driven write/read vectors plus
// directed scan sequences (free-running, toggled ready, snapshot hold, reset abort).
module tb_regfile_scan;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 32;
  localparam int RD_PORTS = 2;
  localparam int ADDR_W   = 5;

  logic                       clk = 1'b0;
  logic                       reset;
  logic                       we;
  logic [ADDR_W-1:0]          waddr;
  logic [DATA_W-1:0]          wdata;
  logic [RD_PORTS*ADDR_W-1:0] raddr;
  logic [RD_PORTS*DATA_W-1:0] rdata;
  logic                       scan_start;
  logic                       scan_busy;
  logic                       scan_valid;
  logic                       scan_ready;
  logic [ADDR_W-1:0]          scan_idx;
  logic [DATA_W-1:0]          scan_data;
  logic                       scan_done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] model [DEPTH];

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] ra0;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] exp0;
    logic [DATA_W-1:0] exp1;
  } vec_t;

  vec_t vecs [11];

  regfile_scan #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .RD_PORTS (RD_PORTS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr      (raddr),
    .rdata      (rdata),
    .scan_start (scan_start),
    .scan_busy  (scan_busy),
    .scan_valid (scan_valid),
    .scan_ready (scan_ready),
    .scan_idx   (scan_idx),
    .scan_data  (scan_data),
    .scan_done  (scan_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one complete dump starting from IDLE and checks every presented entry.
  task automatic run_scan(input bit toggle, input int restart_at);
    int  exp_idx;
    bit  rdy;
    bit  done_seen;
    exp_idx   = 0;
    rdy       = 1'b0;
    done_seen = 1'b0;
    @(negedge clk);
    scan_start = 1'b1;
    scan_ready = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 200 && !done_seen; c++) begin
      #1;
      if (scan_done) begin
        done_seen = 1'b1;
        check("handshake_count", 32'(exp_idx), 32'd32);
        check("done_valid_low", {31'd0, scan_valid}, 32'd0);
        check("done_busy_high", {31'd0, scan_busy}, 32'd1);
      end else if (exp_idx >= DEPTH) begin
        check("scan_overrun", 32'(exp_idx), 32'(DEPTH - 1));
        done_seen = 1'b1;
      end else begin
        check("scan_valid", {31'd0, scan_valid}, 32'd1);
        check("scan_busy", {31'd0, scan_busy}, 32'd1);
        check("scan_idx", {27'd0, scan_idx}, 32'(exp_idx));
        check("scan_data", scan_data, model[exp_idx]);
        rdy        = toggle ? ~rdy : 1'b1;
        scan_ready = rdy;
        scan_start = (c == restart_at);
        if (rdy) exp_idx++;
      end
      @(negedge clk);
    end
    if (!done_seen) check("scan_timeout", 32'd0, 32'd1);
    scan_ready = 1'b0;
    scan_start = 1'b0;
    #1;
    check("done_one_cycle", {31'd0, scan_done}, 32'd0);
    check("idle_busy_low", {31'd0, scan_busy}, 32'd0);
    @(negedge clk);
    #1;
    check("no_queued_restart", {31'd0, scan_busy}, 32'd0);
  endtask

  initial begin
    int done_count;

    vecs[0]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd5,  5'd31, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd0,  5'd1,  32'h0000_0000, 32'h0000_0000};
    vecs[2]  = '{1'b1, 5'd0,  32'h0000_1234, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0000_0000};
    vecs[3]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd0,  5'd5,  32'h0000_0000, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 5'd31, 32'hA5A5_A5A5, 5'd5,  5'd30, 32'hDEAD_BEEF, 32'h0000_0000};
    vecs[5]  = '{1'b1, 5'd3,  32'h0000_0007, 5'd31, 5'd5,  32'hA5A5_A5A5, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b1, 5'd4,  32'h0000_0009, 5'd3,  5'd31, 32'h0000_0007, 32'hA5A5_A5A5};
    vecs[7]  = '{1'b1, 5'd5,  32'hFFFF_FFFF, 5'd4,  5'd3,  32'h0000_0009, 32'h0000_0007};
    vecs[8]  = '{1'b0, 5'd0,  32'h0000_0000, 5'd5,  5'd4,  32'hFFFF_FFFF, 32'h0000_0009};
    vecs[9]  = '{1'b1, 5'd5,  32'hDEAD_BEEF, 5'd1,  5'd2,  32'h0000_0000, 32'h0000_0000};
    vecs[10] = '{1'b0, 5'd0,  32'h0000_0000, 5'd5,  5'd0,  32'hDEAD_BEEF, 32'h0000_0000};

    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

    reset      = 1'b1;
    we         = 1'b0;
    waddr      = 5'd0;
    wdata      = 32'h0;
    raddr      = 10'd0;
    scan_start = 1'b0;
    scan_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, scan_busy}, 32'd0);
    check("rst_valid", {31'd0, scan_valid}, 32'd0);
    check("rst_done", {31'd0, scan_done}, 32'd0);
    check("rst_idx", {27'd0, scan_idx}, 32'd0);
    check("rst_data", scan_data, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      we    = vecs[i].we;
      waddr = vecs[i].waddr;
      wdata = vecs[i].wdata;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      #1;
      check($sformatf("vec%0d_rd0", i), rdata[31:0], vecs[i].exp0);
      check($sformatf("vec%0d_rd1", i), rdata[63:32], vecs[i].exp1);
      if (vecs[i].we && vecs[i].waddr != 5'd0) model[vecs[i].waddr] = vecs[i].wdata;
    end

    // Same-cycle write/read of r9: forwarded only in the bypass build
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd9;
    wdata = 32'h77;
    raddr = {5'd0, 5'd9};
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", rdata[31:0], 32'h77);
`else
    check("no_bypass_same_cycle", rdata[31:0], 32'h0);
`endif
    @(negedge clk);
    we = 1'b0;
    #1;
    check("r9_after_edge", rdata[31:0], 32'h77);
    model[9] = 32'h77;

    run_scan(1'b0, -1);
    run_scan(1'b1, 5);

    // Snapshot hold and write-first loading around idx 6/7
    @(negedge clk);
    we    = 1'b1;
    waddr = 5'd6;
    wdata = 32'h66;
    @(negedge clk);
    we         = 1'b0;
    model[6]   = 32'h66;
    scan_start = 1'b1;
    @(negedge clk);
    scan_start = 1'b0;
    scan_ready = 1'b1;
    repeat (6) @(negedge clk);
    scan_ready = 1'b0;
    #1;
    check("hold_idx6", {27'd0, scan_idx}, 32'd6);
    check("hold_data6", scan_data, 32'h66);
    we    = 1'b1;
    waddr = 5'd6;
    wdata = 32'hAA;
    raddr = {5'd7, 5'd6};
    @(negedge clk);
    we = 1'b0;
    #1;
    check("snapshot_idx6", {27'd0, scan_idx}, 32'd6);
    check("snapshot_data6", scan_data, 32'h66);
    check("write_during_scan", rdata[31:0], 32'hAA);
    scan_ready = 1'b1;
    we         = 1'b1;
    waddr      = 5'd7;
    wdata      = 32'h55;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("writefirst_idx7", {27'd0, scan_idx}, 32'd7);
    check("writefirst_data7", scan_data, 32'h55);
    check("r7_read", rdata[63:32], 32'h55);
    repeat (3) @(negedge clk);
    #1;
    check("at_idx10", {27'd0, scan_idx}, 32'd10);

    // Asynchronous reset mid-scan aborts without a done pulse
    reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, scan_valid}, 32'd0);
    check("abort_busy", {31'd0, scan_busy}, 32'd0);
    check("abort_done", {31'd0, scan_done}, 32'd0);
    check("abort_idx", {27'd0, scan_idx}, 32'd0);
    check("abort_data", scan_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    raddr = {5'd7, 5'd5};
    #1;
    check("r5_cleared", rdata[31:0], 32'd0);
    check("r7_cleared", rdata[63:32], 32'd0);
    done_count = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (scan_done || scan_busy) done_count++;
    end
    check("no_done_after_abort", 32'(done_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
